// File: rtl/hpdl_char_writer_pkg.sv
// Purpose : shared FSM state type and character constants for the HPDL1414 character writer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package hpdl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        STROBE     = 3'd2,
        HOLD       = 3'd3,
        CLEAR_NEXT = 3'd4
    } state_t;

    localparam int         NUM_POS   = 16;
    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_MAX   = 8'h5F;

endpackage

// File: rtl/hpdl_char_writer_phase_timer.sv
// Purpose : loadable down-counter; o_done pulses in the last cycle of a loaded phase.
// Latency : a load of N-1 gives done in the Nth cycle after the load edge.
// Backpressure: none; a load always wins over the running count.
//
// Ports: i_clk, i_rst (async active-high), i_load / i_load_val (phase length - 1),
//        o_done (high for one cycle at the end of the phase).
module hpdl_phase_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;
    logic         r_active;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= i_load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_done = r_active && (r_cnt == '0);

endmodule

// File: rtl/hpdl_char_writer.sv
// Purpose : byte stream -> four chained HPDL1414 displays with cursor, CR/BS/FF handling.
// Latency : printable byte: 6 busy cycles (S+P+H), ready again in cycle 7; FF: 111 busy cycles.
// Backpressure: ready_o high only in IDLE; upstream holds the byte while ready_o is low.
//
// Ports: CLK_i, RST_i (async active-high), data_i/valid_i/ready_o byte input,
//        hpdl_d_o (D6..D0), hpdl_a_o (A1..A0), hpdl_wr_n_o (one WR_n per display),
//        cursor_o (0..15).
// Build option: define HPDL_CLEAR_ON_RESET_EN to run the clear sequence after reset.
module hpdl_char_writer
    import hpdl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [6:0] hpdl_d_o,
    output logic [1:0] hpdl_a_o,
    output logic [3:0] hpdl_wr_n_o,
    output logic [3:0] cursor_o
);

    localparam int TW = 16;

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
        $error("hpdl_char_writer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end

    state_t      r_state;
    logic        r_ready;
    logic [6:0]  r_d;
    logic [1:0]  r_a;
    logic [1:0]  r_sel;
    logic [3:0]  r_wr_n;
    logic [3:0]  r_cursor;
    logic [3:0]  r_clr_pos;
    logic        r_clearing;

    logic        w_accept;
    logic        w_is_print;
    logic        w_is_lower;
    logic        w_is_write;
    logic        w_is_ff;
    logic [6:0]  w_char;
    logic        w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic        w_tmr_done;

    // Byte classifier
    assign w_is_print = (data_i >= CHR_SPACE) && (data_i <= CHR_MAX);
    assign w_is_lower = (data_i >= 8'h61) && (data_i <= 8'h7A);
    assign w_is_write = w_is_print || w_is_lower;
    assign w_is_ff    = (data_i == CHR_FF);
    assign w_char     = w_is_lower ? (data_i[6:0] - 7'h20) : data_i[6:0];

    // r_ready is only ever high in IDLE, so this is also the IDLE qualifier.
    assign w_accept = valid_i && r_ready;

    // One timer serves all three phases; it is reloaded on every phase entry.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TW'(SETUP_CYC - 1);
        case (r_state)
            IDLE:       w_tmr_load = w_accept && (w_is_write || w_is_ff);
            CLEAR_NEXT: w_tmr_load = 1'b1;
            SETUP: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = TW'(PULSE_CYC - 1);
            end
            STROBE: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = TW'(HOLD_CYC - 1);
            end
            default: w_tmr_load = 1'b0;
        endcase
    end

    hpdl_phase_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (CLK_i),
        .i_rst      (RST_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Data/address/select are only loaded in IDLE and CLEAR_NEXT, where every WR_n is high.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
`ifdef HPDL_CLEAR_ON_RESET_EN
            r_state    <= CLEAR_NEXT;
            r_clearing <= 1'b1;
`else
            r_state    <= IDLE;
            r_clearing <= 1'b0;
`endif
            r_ready    <= 1'b0;
            r_d        <= '0;
            r_a        <= '0;
            r_sel      <= '0;
            r_wr_n     <= 4'hF;
            r_cursor   <= '0;
            r_clr_pos  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_is_write) begin
                            r_d        <= w_char;
                            r_a        <= 2'd3 - r_cursor[1:0];
                            r_sel      <= r_cursor[3:2];
                            r_clearing <= 1'b0;
                            r_ready    <= 1'b0;
                            r_state    <= SETUP;
                        end else if (w_is_ff) begin
                            r_d        <= CHR_SPACE[6:0];
                            r_a        <= 2'd3;
                            r_sel      <= 2'd0;
                            r_clr_pos  <= 4'd0;
                            r_clearing <= 1'b1;
                            r_ready    <= 1'b0;
                            r_state    <= SETUP;
                        end else if (data_i == CHR_CR) begin
                            r_cursor <= 4'd0;
                        end else if (data_i == CHR_BS && r_cursor != 4'd0) begin
                            r_cursor <= r_cursor - 4'd1;
                        end
                    end
                end
                SETUP: begin
                    if (w_tmr_done) begin
                        r_wr_n  <= ~(4'b0001 << r_sel);
                        r_state <= STROBE;
                    end
                end
                STROBE: begin
                    if (w_tmr_done) begin
                        r_wr_n  <= 4'hF;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_tmr_done) begin
                        if (r_clearing) begin
                            if (r_clr_pos == 4'(NUM_POS - 1)) begin
                                r_cursor   <= 4'd0;
                                r_clearing <= 1'b0;
                                r_ready    <= 1'b1;
                                r_state    <= IDLE;
                            end else begin
                                r_clr_pos <= r_clr_pos + 4'd1;
                                r_state   <= CLEAR_NEXT;
                            end
                        end else begin
                            r_cursor <= r_cursor + 4'd1;
                            r_ready  <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                end
                CLEAR_NEXT: begin
                    r_d     <= CHR_SPACE[6:0];
                    r_a     <= 2'd3 - r_clr_pos[1:0];
                    r_sel   <= r_clr_pos[3:2];
                    r_state <= SETUP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o     = r_ready;
    assign hpdl_d_o    = r_d;
    assign hpdl_a_o    = r_a;
    assign hpdl_wr_n_o = r_wr_n;
    assign cursor_o    = r_cursor;

endmodule

// File: tb/tb_hpdl_char_writer.sv
// Purpose : randomized + directed bench for hpdl_char_writer with a write scoreboard.
// Latency : checks ready-return latency and final cursor for every byte sent.
// Backpressure: bytes are only presented once ready_o is high.
module tb_hpdl_char_writer;

    localparam int S = 2;
    localparam int P = 2;
    localparam int H = 2;
    localparam int WRITE_BUSY = S + P + H;
    localparam int CLEAR_BUSY = 16 * (S + P + H) + 15;

    typedef struct packed {
        logic [3:0] wr;
        logic [1:0] a;
        logic [6:0] d;
    } wr_t;

    logic       CLK_i = 1'b0;
    logic       RST_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [6:0] hpdl_d_o;
    logic [1:0] hpdl_a_o;
    logic [3:0] hpdl_wr_n_o;
    logic [3:0] cursor_o;

    int   errors = 0;
    int   checks = 0;
    int   m_cursor = 0;
    logic mon_en = 1'b1;
    wr_t  sb[$];

    hpdl_char_writer #(
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .HOLD_CYC  (H)
    ) dut (
        .CLK_i       (CLK_i),
        .RST_i       (RST_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .hpdl_d_o    (hpdl_d_o),
        .hpdl_a_o    (hpdl_a_o),
        .hpdl_wr_n_o (hpdl_wr_n_o),
        .cursor_o    (cursor_o)
    );

    always #42 CLK_i = ~CLK_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected write of a character at display position pos (0..15, left to right).
    function automatic void push_w(input int pos, input logic [6:0] ch);
        wr_t e;
        e.wr = 4'hF & ~(4'b0001 << (pos / 4));
        e.a  = 2'(3 - (pos % 4));
        e.d  = ch;
        sb.push_back(e);
    endfunction

    function automatic void push_clear();
        for (int p = 0; p < 16; p++) push_w(p, 7'h20);
    endfunction

    // Reference behaviour of one accepted byte; returns cycles ready_o stays low.
    function automatic int model_byte(input logic [7:0] b);
        logic [7:0] t;
        if ((b >= 8'h20 && b <= 8'h5F) || (b >= 8'h61 && b <= 8'h7A)) begin
            t = (b >= 8'h61) ? b - 8'h20 : b;
            push_w(m_cursor, t[6:0]);
            m_cursor = (m_cursor + 1) % 16;
            return WRITE_BUSY;
        end
        if (b == 8'h0D) m_cursor = 0;
        else if (b == 8'h08) m_cursor = (m_cursor > 0) ? m_cursor - 1 : 0;
        else if (b == 8'h0C) begin
            push_clear();
            m_cursor = 0;
            return CLEAR_BUSY;
        end
        return 0;
    endfunction

    task automatic wait_ready(input int limit, input string name);
        int n = 0;
        while (!ready_o && n < limit) begin
            @(negedge CLK_i);
            n++;
        end
        if (!ready_o) chk(name, 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int exp_busy;
        int busy;
        @(negedge CLK_i);
        wait_ready(400, "ready_wait");
        data_i  = b;
        valid_i = 1'b1;
        @(posedge CLK_i);
        #1;
        valid_i  = 1'b0;
        exp_busy = model_byte(b);
        busy     = 0;
        @(negedge CLK_i);
        while (!ready_o && busy < 400) begin
            busy++;
            @(negedge CLK_i);
        end
        chk($sformatf("busy_%02h", b), busy, exp_busy);
        chk($sformatf("cursor_%02h", b), int'(cursor_o), m_cursor);
        chk($sformatf("sb_drain_%02h", b), sb.size(), 0);
    endtask

    // Monitor: every WR_n strobe is popped from the scoreboard and its timing checked.
    initial begin : monitor
        logic [3:0] prev_wr;
        logic [8:0] cur, h1, h2, ref_ad;
        int         low_n;
        int         hold_left;
        wr_t        e;
        prev_wr = 4'hF; low_n = 0; hold_left = 0;
        h1 = '0; h2 = '0; ref_ad = '0;
        forever begin
            @(negedge CLK_i);
            cur = {hpdl_a_o, hpdl_d_o};
            if (!mon_en) begin
                low_n = 0;
                hold_left = 0;
                prev_wr = 4'hF;
            end else begin
                if (hpdl_wr_n_o != 4'hF && prev_wr == 4'hF) begin
                    chk("setup_stable", int'(h1 == cur && h2 == cur), 1);
                    if (sb.size() == 0) begin
                        chk("unexpected_write", int'(hpdl_wr_n_o), 15);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_sel", int'(hpdl_wr_n_o), int'(e.wr));
                        chk("addr", int'(hpdl_a_o), int'(e.a));
                        chk("data", int'(hpdl_d_o), int'(e.d));
                    end
                    ref_ad = cur;
                    low_n  = 1;
                end else if (hpdl_wr_n_o != 4'hF) begin
                    low_n++;
                    chk("strobe_stable", int'(cur), int'(ref_ad));
                end else if (prev_wr != 4'hF) begin
                    chk("pulse_width", low_n, P);
                    chk("hold_stable", int'(cur), int'(ref_ad));
                    hold_left = H - 1;
                end else if (hold_left > 0) begin
                    hold_left--;
                    chk("hold_stable", int'(cur), int'(ref_ad));
                end
                prev_wr = hpdl_wr_n_o;
            end
            h2 = h1;
            h1 = cur;
        end
    end

    initial begin : watchdog
        #(84 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b;
        int         r;
        int         n;
        // Reset values
        repeat (3) @(negedge CLK_i);
        chk("rst_d", int'(hpdl_d_o), 0);
        chk("rst_a", int'(hpdl_a_o), 0);
        chk("rst_wr", int'(hpdl_wr_n_o), 15);
        chk("rst_cursor", int'(cursor_o), 0);
        chk("rst_ready", int'(ready_o), 0);
`ifdef HPDL_CLEAR_ON_RESET_EN
        push_clear();
`endif
        @(posedge CLK_i);
        #1 RST_i = 1'b0;

        // Single 'A'
        send_byte(8'h41);
        // Wrap-around stream of 17 characters from position 0
        send_byte(8'h0D);
        for (int i = 0; i < 17; i++) send_byte(8'(8'h30 + i));
        // Case folding and ignored bytes
        send_byte(8'h61);
        send_byte(8'h7F);
        send_byte(8'h0A);
        // Backspace saturation
        send_byte(8'h0D);
        for (int i = 0; i < 5; i++) send_byte(8'h48);
        for (int i = 0; i < 7; i++) send_byte(8'h08);
        // CR from cursor 9
        for (int i = 0; i < 9; i++) send_byte(8'h7A);
        send_byte(8'h0D);
        // Form feed
        send_byte(8'h0C);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      b = 8'h0D;
            else if (r < 3)  b = 8'h08;
            else if (r == 3) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b);
        end

        // Reset asserted during STROBE
        send_byte(8'h0D);
        mon_en = 1'b0;
        @(negedge CLK_i);
        data_i  = 8'h52;
        valid_i = 1'b1;
        @(posedge CLK_i);
        #1 valid_i = 1'b0;
        n = 0;
        while (hpdl_wr_n_o == 4'hF && n < 20) begin
            @(negedge CLK_i);
            n++;
        end
        chk("strobe_seen", int'(hpdl_wr_n_o != 4'hF), 1);
        #5 RST_i = 1'b1;
        #1;
        chk("rst_async_wr", int'(hpdl_wr_n_o), 15);
        chk("rst_async_ready", int'(ready_o), 0);
        sb.delete();
        m_cursor = 0;
        repeat (2) @(negedge CLK_i);
        chk("rst_mid_cursor", int'(cursor_o), 0);
`ifdef HPDL_CLEAR_ON_RESET_EN
        push_clear();
`endif
        @(posedge CLK_i);
        #1;
        RST_i  = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK_i);
        wait_ready(400, "ready_after_rst");
        chk("post_rst_drain", sb.size(), 0);
        chk("post_rst_cursor", int'(cursor_o), 0);
        // Abandoned write must not have moved the cursor; normal operation resumes.
        send_byte(8'h21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpdl_char_writer.md
# hpdl_char_writer

Consumes a byte stream from the UART receiver and writes printable characters to four chained HPDL1414 displays (16 positions), with a moving cursor and the display's setup, pulse and hold write timing. Sits between the UART RX byte output and the HPDL data, address and WR pins in the HPDL1414 PMOD top level. Handles a small set of control characters: carriage return, backspace and form feed.

## Interface
- `SETUP_CYC`, 2: cycles that address and data are stable before the WR strobe.
- `PULSE_CYC`, 2: cycles that WR is held low.
- `HOLD_CYC`, 2: cycles that address and data are held after WR rises.
- `CLK_i` in 1: single clock, 12 MHz.
- `RST_i` in 1: asynchronous, active-high reset.
- `data_i` in 8: received byte.
- `valid_i` in 1: `data_i` is valid.
- `ready_o` out 1: the block accepts a byte when `valid_i && ready_o`.
- `hpdl_d_o` out 7: HPDL data D6..D0.
- `hpdl_a_o` out 2: digit address A1..A0.
- `hpdl_wr_n_o` out 4: active-low write strobe, one per display.
- `cursor_o` out 4: current cursor position, 0..15.

## Operation
- Reset values:
  - `hpdl_d_o`=0, `hpdl_a_o`=0, `hpdl_wr_n_o`=4'hF, `cursor_o`=0.
  - `ready_o`=0 while `RST_i` is high.
- States: IDLE, SETUP, STROBE, HOLD and CLEAR_NEXT.
- Byte classification on acceptance:
  - 0x20..0x5F is printable and is written as is.
  - 0x61..0x7A is folded to uppercase by subtracting 0x20, then written.
  - 0x0D (CR): cursor←0, no write.
  - 0x08 (BS): cursor←cursor-1, saturating at 0, no write.
  - 0x0C (FF): clear sequence.
  - Every other byte is consumed and ignored.
- Cursor-to-pin mapping:
  - Display select = `cursor[3:2]`; only WR_n of that display pulses.
  - `hpdl_a_o` = 3 − `cursor[1:0]`, because HPDL digit 0 is the rightmost.
- Write sequence for printable bytes:
  - IDLE→SETUP: latch the character into `hpdl_d_o` and the address into `hpdl_a_o`.
  - SETUP→STROBE→HOLD→IDLE.
  - Cursor increments on HOLD exit. Wrap-around: 15→0.
- Clear sequence:
  - Writes 0x20 to positions 0..15 in order; each position is a full SETUP/STROBE/HOLD pass.
  - CLEAR_NEXT advances the position between passes.
  - Cursor ends at 0.
- `ready_o` is high only in IDLE when out of reset.
  - Ignored and control bytes (CR, BS) are consumed in one cycle and `ready_o` stays high.
- Data and address never change while any `hpdl_wr_n_o` bit is low.
- `valid_i` with `ready_o` low has no effect. The upstream block holds the byte.

## Timing
- Accept at edge 0.
- SETUP covers cycles 1..`SETUP_CYC`.
- STROBE covers the next `PULSE_CYC` cycles.
- HOLD covers the next `HOLD_CYC` cycles.
- `ready_o` returns high in cycle `SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`+1, which is 7 with the defaults.
- Sustained throughput: one character per 7 cycles, about 583 ns at 12 MHz. This is faster than 115200 baud.
- Clear duration: 16×(S+P+H)+15 cycles, 111 with the defaults.
- `cursor_o` updates in the cycle after HOLD completes.
- Timing parameters below 1 are illegal and are flagged by an elaboration-time check.
- Reset asserted mid-write:
  - `hpdl_wr_n_o` goes to 4'hF immediately, without waiting for a clock.
  - The state returns to IDLE and the partial write is abandoned.

## Configuration
- `HPDL_CLEAR_ON_RESET_EN`
  - Defined: after reset deasserts, the FSM runs the clear sequence automatically. `ready_o` stays low until it completes, so the first accept happens no earlier than cycle 112.
  - Undefined: the FSM enters IDLE directly and `ready_o` rises in the first cycle after reset deasserts. Display contents are undefined until the host sends FF.

## Structure
- Package `hpdl_pkg` holds:
  - The FSM state enum.
  - Constants `NUM_POS`=16, `CHR_SPACE`=8'h20, `CHR_CR`=8'h0D, `CHR_BS`=8'h08, `CHR_FF`=8'h0C, `CHR_MAX`=8'h5F.
- Sub-module `hpdl_phase_timer` is a loadable down-counter that produces a `done` pulse. It is shared by SETUP, STROBE and HOLD.
- The byte classifier is combinational logic inside the top module.

## Test plan
- Reset, then 'A' (0x41): D=0x41, A=3, WR_n=4'b1110 low for exactly 2 cycles, data stable ±2 cycles around the strobe; `cursor_o`=1; `ready_o` high again at cycle 7.
- Stream 17 printable bytes 0x30..0x40: positions 0..15 are written with 0x30..0x3F on WR_n[0..3] in turn; the 17th byte (0x40) lands at position 0 with WR_n[0], A=3; final cursor=1.
- 'a' (0x61) → writes 0x41; 0x7F and 0x0A → consumed in one cycle, no WR activity, cursor unchanged.
- Cursor at 5, then BS ×7 → cursor 0 with no writes; then CR at cursor 9 → cursor 0.
- FF → 16 writes of 0x20 covering every (display, address) pair once; `ready_o` low for 111 cycles; cursor 0.
- Assert `RST_i` during STROBE → `hpdl_wr_n_o`=4'hF in the same cycle with no clock edge; with `HPDL_CLEAR_ON_RESET_EN` defined, 16 clear writes follow reset release.
